// File: rtl/booth_seq_multiplier.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock, start/done handshake,
// run-time signed/unsigned operands, registered outputs only.
module booth_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int E  = WIDTH + 1;
  localparam int CW = $clog2(E + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [E-1:0]       a_q, a_d;
  logic [E-1:0]       q_q, q_d;
  logic [E-1:0]       m_q, m_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [E-1:0]       a_sum_s;
  logic [E-1:0]       a_step_s;
  logic [E-1:0]       q_step_s;
  logic               q1_step_s;
  logic [2*E-1:0]     aq_step_s;
  logic               accept_s;

  // One Booth step: add/subtract M by {Q[0],Q_1}, then arithmetic right shift of {A,Q,Q_1}
  always_comb begin
    a_sum_s = a_q;
    case ({q_q[0], q1_q})
      2'b10:   a_sum_s = a_q - m_q;
      2'b01:   a_sum_s = a_q + m_q;
      default: a_sum_s = a_q;
    endcase
    {a_step_s, q_step_s, q1_step_s} = {a_sum_s[E-1], a_sum_s, q_q};
    aq_step_s = {a_step_s, q_step_s};
  end

  assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          // Extension bit makes the most-negative operand safe to negate
          state_d = RUN;
          a_d     = {E{1'b0}};
          q_d     = {signed_mode & multiplier[WIDTH-1], multiplier};
          m_d     = {signed_mode & multiplicand[WIDTH-1], multiplicand};
          q1_d    = 1'b0;
          cnt_d   = CW'(E);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_step_s;
        q_d   = q_step_s;
        q1_d  = q1_step_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          product_d = aq_step_s[2*WIDTH-1:0];
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; synchronous reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= {E{1'b0}};
      q_q       <= {E{1'b0}};
      m_q       <= {E{1'b0}};
      q1_q      <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= {2*WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed, table-driven bench for booth_seq_multiplier at WIDTH=8, plus hand-written
// sequences for mid-run input changes, mid-run reset and back-to-back accepts.
module tb_booth_seq_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           sm;
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept one operation and observe 14 cycles; cycle c is the one following edge N+c.
  task automatic run_op(input string name, input logic sm, input logic [W-1:0] mc,
                        input logic [W-1:0] mp, input logic [2*W-1:0] exp, input bit perturb);
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [2*W-1:0] prod_at_done;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    prod_at_done = '0;
    @(negedge clk);
    start = 1'b1; signed_mode = sm; multiplicand = mc; multiplier = mp;
    @(posedge clk);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c;
          prod_at_done = product;
          check({name, " busy_in_done"}, 32'(busy), 32'd0);
        end
      end
      start = 1'b0;
      if (perturb && c == 3) begin
        start = 1'b1; signed_mode = ~sm; multiplicand = 8'h11; multiplier = 8'h22;
      end
    end
    check({name, " product"}, 32'(prod_at_done), 32'(exp));
    check({name, " done_cycle"}, 32'(done_at), 32'd9);
    check({name, " done_count"}, 32'(done_cnt), 32'd1);
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'd9);
    check({name, " product_held"}, 32'(product), 32'(exp));
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"u5x3",      1'b0, 8'd5,   8'd3,   16'h000F};
    vecs[1] = '{"s-7x13",    1'b1, 8'hF9,  8'd13,  16'hFFA5};
    vecs[2] = '{"s-128x-128",1'b1, 8'h80,  8'h80,  16'h4000};
    vecs[3] = '{"s127x-128", 1'b1, 8'h7F,  8'h80,  16'hC080};
    vecs[4] = '{"u255x255",  1'b0, 8'hFF,  8'hFF,  16'hFE01};
    vecs[5] = '{"u80x02",    1'b0, 8'h80,  8'h02,  16'h0100};
    vecs[6] = '{"s80x02",    1'b1, 8'h80,  8'h02,  16'hFF00};
    vecs[7] = '{"s-1x-1",    1'b1, 8'hFF,  8'hFF,  16'h0001};
    vecs[8] = '{"u0x200",    1'b0, 8'd0,   8'd200, 16'h0000};
    vecs[9] = '{"s-2x3",     1'b1, 8'hFE,  8'd3,   16'hFFFA};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].sm, vecs[i].mc, vecs[i].mp, vecs[i].exp, 1'b0);
    end

    // Start pulse and operand changes during RUN must be ignored
    run_op("midrun_ignore", 1'b0, 8'd100, 8'd7, 16'h02BC, 1'b1);

    // Reset on the 4th RUN cycle
    begin
      int done_cnt;
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid busy", 32'(busy), 32'd0);
      check("rst_mid done", 32'(done), 32'd0);
      check("rst_mid product", 32'(product), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        if (done || busy) done_cnt++;
      end
      check("rst_mid no_activity", 32'(done_cnt), 32'd0);
      run_op("after_rst 25x39", 1'b0, 8'd25, 8'd39, 16'h03CF, 1'b0);
    end

    // Start held high: back-to-back accept from DONE
    begin
      int done_cnt;
      int first_at;
      int second_at;
      done_cnt = 0; first_at = -1; second_at = -1;
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; multiplicand = 8'd123; multiplier = 8'd125;
      @(posedge clk);
      for (int c = 0; c < 24; c++) begin
        @(negedge clk);
        if (done) begin
          done_cnt++;
          if (first_at < 0) begin
            first_at = c;
            check("b2b first product", 32'(product), 32'h3C0F);
          end else if (second_at < 0) begin
            second_at = c;
            check("b2b second product", 32'(product), 32'h001E);
          end
        end
        if (c == 9) begin
          multiplicand = 8'd10; multiplier = 8'd3;
        end
        if (c == 10) start = 1'b0;
      end
      check("b2b first_at", 32'(first_at), 32'd9);
      check("b2b spacing", 32'(second_at - first_at), 32'd10);
      check("b2b done_count", 32'(done_cnt), 32'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
